// File: rtl/game_pkg.sv
// Shared definitions for the game-stage driver: FSM states, LFSR geometry
// and evaluator operand widths.
package game_pkg;

  localparam int LFSR_W   = 10;
  localparam int TAP_HI   = 9;   // x^10 term
  localparam int TAP_LO   = 6;   // x^7 term
  localparam int EFFORT_W = 7;
  localparam int HARD_W   = 5;
  localparam int RAND_W   = 5;
  localparam int BONUS_W  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRIVE  = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // An all-zero Fibonacci LFSR locks up, so a zero seed is forced to 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
  endfunction

  // One step of x^10 + x^7 + 1, shifting toward the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[TAP_HI] ^ cur[TAP_LO]};
  endfunction

endpackage

// File: rtl/game_lfsr10.sv
// 10-bit Fibonacci LFSR supplying the hard/random2 operands.
// load re-seeds (zero seed guarded), en advances one step.
module game_lfsr10
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 10'h2A5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  // Seed on reset and on load; otherwise step only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= lfsr_seed_fix(SEED);
    end else if (load) begin
      value <= lfsr_seed_fix(SEED);
    end else if (en) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/game_stage_driver.sv
// Sequential producer for the combinational game-stage evaluator.
// Accepts one player record per LOAD, holds operands through DRIVE so the
// evaluator settles, samples its result in SAMPLE and accumulates totals.
// Optional macro GAME_STAGE_DRV_ABORT_EN adds an abort input that drops
// the round back to IDLE, keeping partial totals.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; start clears index/totals and reseeds LFSR
// LOAD   | eff_ready=1; accepted record + LFSR operands go to stg_*
// DRIVE  | stg_* held one full cycle for evaluator settling
// SAMPLE | capture pass2/bonus2, pulse res_valid, accumulate, step LFSR
// DONE   | done pulse; totals hold until the next accepted start
module game_stage_driver
  import game_pkg::*;
#(
  parameter int                NUM_PLAYERS = 8,
  parameter int                CNT_W       = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 10'h2A5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef GAME_STAGE_DRV_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 eff_valid,
  output logic                 eff_ready,
  input  logic [EFFORT_W-1:0]  eff_effort,
  input  logic                 eff_pass1,
  input  logic [BONUS_W-1:0]   eff_bonus1,
  output logic [EFFORT_W-1:0]  stg_effort,
  output logic [HARD_W-1:0]    stg_hard,
  output logic [RAND_W-1:0]    stg_random2,
  output logic                 stg_pass1,
  output logic [BONUS_W-1:0]   stg_bonus1,
  input  logic                 stg_pass2,
  input  logic [BONUS_W-1:0]   stg_bonus2,
  output logic                 res_valid,
  output logic [CNT_W-1:0]     res_idx,
  output logic                 res_pass,
  output logic [BONUS_W-1:0]   res_bonus,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W+1:0]     bonus_sum
);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  idx;
  logic [LFSR_W-1:0] lfsr_q;
  logic              abort_hit;
  logic              last_player;
  logic              round_start;
  logic              capture;
  logic              sample;

`ifdef GAME_STAGE_DRV_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign last_player = (idx == CNT_W'(NUM_PLAYERS - 1));
  assign done        = (state == DONE);

  game_lfsr10 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (round_start),
    .en    (sample),
    .value (lfsr_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state control strobes. An abort beats a
  // concurrent handshake or sample so the interrupted player leaves no trace.
  always_comb begin
    state_nxt   = state;
    eff_ready   = 1'b0;
    round_start = 1'b0;
    capture     = 1'b0;
    sample      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          round_start = 1'b1;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        eff_ready = 1'b1;
        if (abort_hit) begin
          state_nxt = IDLE;
        end else if (eff_valid) begin
          capture   = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        state_nxt = abort_hit ? IDLE : SAMPLE;
      end
      SAMPLE: begin
        if (abort_hit) begin
          state_nxt = IDLE;
        end else begin
          sample    = 1'b1;
          state_nxt = last_player ? DONE : LOAD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand registers toward the evaluator; nothing reaches stg_* without a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_effort  <= '0;
      stg_hard    <= '0;
      stg_random2 <= '0;
      stg_pass1   <= 1'b0;
      stg_bonus1  <= '0;
    end else if (capture) begin
      stg_effort  <= eff_effort;
      stg_pass1   <= eff_pass1;
      stg_bonus1  <= eff_bonus1;
      stg_hard    <= lfsr_q[HARD_W-1:0];
      stg_random2 <= lfsr_q[HARD_W +: RAND_W];
    end
  end

  // Per-player result capture, player index and round totals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_pass  <= 1'b0;
      res_bonus <= '0;
      pass_cnt  <= '0;
      bonus_sum <= '0;
    end else begin
      res_valid <= 1'b0;
      if (round_start) begin
        idx       <= '0;
        pass_cnt  <= '0;
        bonus_sum <= '0;
      end
      if (sample) begin
        res_valid <= 1'b1;
        res_idx   <= idx;
        res_pass  <= stg_pass2;
        res_bonus <= stg_bonus2;
        pass_cnt  <= pass_cnt + CNT_W'(stg_pass2);
        bonus_sum <= bonus_sum + (CNT_W+2)'(stg_bonus2);
        if (!last_player) begin
          idx <= idx + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_stage_driver.sv
// Scoreboard bench for game_stage_driver: stimulus pushes expected results,
// monitors pop and compare on res_valid and done.
module tb_game_stage_driver;

  localparam int NP = 8;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        eff_valid = 1'b0;
  logic        eff_ready;
  logic [6:0]  eff_effort = '0;
  logic        eff_pass1 = 1'b0;
  logic [1:0]  eff_bonus1 = '0;
  logic [6:0]  stg_effort;
  logic [4:0]  stg_hard;
  logic [4:0]  stg_random2;
  logic        stg_pass1;
  logic [1:0]  stg_bonus1;
  logic        stg_pass2;
  logic [1:0]  stg_bonus2;
  logic        res_valid;
  logic [CW-1:0] res_idx;
  logic        res_pass;
  logic [1:0]  res_bonus;
  logic        done;
  logic [CW-1:0] pass_cnt;
  logic [CW+1:0] bonus_sum;

  int mode = 0;
  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [3:0] idx; logic p; logic [1:0] b; } res_t;
  typedef struct packed { logic [3:0] pc; logic [5:0] bs; } done_t;
  res_t  res_q[$];
  done_t done_q[$];

  logic [9:0] m_lfsr;
  int         m_idx, m_pc, m_bs;
  int         last_e, last_h;

  int eff_tab[8]  = '{90, 10, 127, 45, 60, 33, 100, 7};
  int p1_tab[8]   = '{1, 1, 0, 1, 1, 0, 1, 1};
  int b1_tab[8]   = '{0, 2, 1, 3, 2, 0, 1, 3};

  game_stage_driver #(
    .NUM_PLAYERS (NP),
    .CNT_W       (CW),
    .LFSR_SEED   (10'h2A5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef GAME_STAGE_DRV_ABORT_EN
    .abort       (abort),
`endif
    .eff_valid   (eff_valid),
    .eff_ready   (eff_ready),
    .eff_effort  (eff_effort),
    .eff_pass1   (eff_pass1),
    .eff_bonus1  (eff_bonus1),
    .stg_effort  (stg_effort),
    .stg_hard    (stg_hard),
    .stg_random2 (stg_random2),
    .stg_pass1   (stg_pass1),
    .stg_bonus1  (stg_bonus1),
    .stg_pass2   (stg_pass2),
    .stg_bonus2  (stg_bonus2),
    .res_valid   (res_valid),
    .res_idx     (res_idx),
    .res_pass    (res_pass),
    .res_bonus   (res_bonus),
    .done        (done),
    .pass_cnt    (pass_cnt),
    .bonus_sum   (bonus_sum)
  );

  always #5 clk = ~clk;

  // Stand-in evaluator: mode 0 always pass/bonus 2, mode 1 a simple rule.
  function automatic logic [2:0] eval(input int md, input logic [6:0] e, input logic [4:0] h,
                                      input logic [4:0] r, input logic p1, input logic [1:0] b1);
    logic p;
    if (md == 0) return 3'b110;
    p = p1 && ({1'b0, e} > ({3'b0, h} + {3'b0, r}));
    return {p, p ? (b1 ^ r[1:0]) : 2'b00};
  endfunction

  function automatic logic [9:0] lnext(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  always_comb begin
    {stg_pass2, stg_bonus2} = eval(mode, stg_effort, stg_hard, stg_random2, stg_pass1, stg_bonus1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Result monitor.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 1, 0);
      end else begin
        res_t e;
        e = res_q.pop_front();
        chk("mon_res_idx", int'(res_idx), int'(e.idx));
        chk("mon_res_pass", int'(res_pass), int'(e.p));
        chk("mon_res_bonus", int'(res_bonus), int'(e.b));
      end
    end
  end

  // Round-completion monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("mon_pass_cnt", int'(pass_cnt), int'(d.pc));
        chk("mon_bonus_sum", int'(bonus_sum), int'(d.bs));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_lfsr = 10'h2A5;
    m_idx = 0;
    m_pc = 0;
    m_bs = 0;
    chk("start_ready", int'(eff_ready), 1);
  endtask

  task automatic send(input int e, input int p1, input int b1, input int stall, input bit poke);
    int guard;
    logic [2:0] r;
    guard = 0;
    while (eff_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("ready_wait", int'(eff_ready), 1);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_ready", int'(eff_ready), 1);
      chk("stall_res", int'(res_valid), 0);
      chk("stall_effort", int'(stg_effort), last_e);
      chk("stall_hard", int'(stg_hard), last_h);
    end
    eff_effort = 7'(e);
    eff_pass1  = 1'(p1);
    eff_bonus1 = 2'(b1);
    eff_valid  = 1'b1;
    step();
    eff_valid  = 1'b0;
    chk("acc_effort", int'(stg_effort), e);
    chk("acc_hard", int'(stg_hard), int'(m_lfsr[4:0]));
    chk("acc_rand", int'(stg_random2), int'(m_lfsr[9:5]));
    chk("acc_pass1", int'(stg_pass1), p1);
    chk("acc_bonus1", int'(stg_bonus1), b1);
    chk("drive_ready", int'(eff_ready), 0);
    last_e = e;
    last_h = int'(m_lfsr[4:0]);
    r = eval(mode, 7'(e), m_lfsr[4:0], m_lfsr[9:5], 1'(p1), 2'(b1));
    res_q.push_back('{idx: 4'(m_idx), p: r[2], b: r[1:0]});
    m_pc += int'(r[2]);
    m_bs += int'(r[1:0]);
    if (poke) begin
      start = 1'b1;
      step();
      start = 1'b0;
      eff_valid = 1'b1;
    end else begin
      step();
    end
    chk("lat_early", int'(res_valid), 0);
    step();
    eff_valid = 1'b0;
    chk("lat_res", int'(res_valid), 1);
    chk("lat_idx", int'(res_idx), m_idx);
    m_lfsr = lnext(m_lfsr);
    m_idx++;
    if (m_idx == NP) done_q.push_back('{pc: 4'(m_pc), bs: 6'(m_bs)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(eff_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass_cnt", int'(pass_cnt), 0);
    chk("rst_bonus_sum", int'(bonus_sum), 0);
    chk("rst_hard", int'(stg_hard), 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", int'(eff_ready), 0);

    // Round 1: constant evaluator, stall on player 2, pokes on player 3
    mode = 0;
    do_start();
    for (int i = 0; i < NP; i++) begin
      send(eff_tab[i], p1_tab[i], b1_tab[i], (i == 2) ? 5 : 0, (i == 3));
      if (i == 0) begin
        chk("p0_hard", int'(stg_hard), 5);
        chk("p0_rand", int'(stg_random2), 21);
      end
      if (i == 1) begin
        chk("p1_hard", int'(stg_hard), 11);
        chk("p1_rand", int'(stg_random2), 10);
      end
    end
    chk("r1_done", int'(done), 1);
    chk("r1_pass_cnt", int'(pass_cnt), 8);
    chk("r1_bonus_sum", int'(bonus_sum), 16);
    step();
    chk("r1_done_clear", int'(done), 0);
    chk("r1_pass_hold", int'(pass_cnt), 8);
    chk("r1_bonus_hold", int'(bonus_sum), 16);
    eff_valid = 1'b1;
    repeat (3) begin
      step();
      chk("idle_valid_ready", int'(eff_ready), 0);
    end
    eff_valid = 1'b0;

    // Round 2: rule evaluator, async reset in DRIVE of player 3
    mode = 1;
    do_start();
    for (int i = 0; i < 3; i++) send(eff_tab[i], p1_tab[i], b1_tab[i], 0, 1'b0);
    eff_effort = 7'd55;
    eff_pass1  = 1'b1;
    eff_bonus1 = 2'd1;
    eff_valid  = 1'b1;
    step();
    eff_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_effort", int'(stg_effort), 0);
    chk("arst_hard", int'(stg_hard), 0);
    chk("arst_rand", int'(stg_random2), 0);
    chk("arst_pass_cnt", int'(pass_cnt), 0);
    chk("arst_bonus_sum", int'(bonus_sum), 0);
    chk("arst_res_idx", int'(res_idx), 0);
    #3;
    rst_n = 1'b1;
    step();
    do_start();
    for (int i = 0; i < NP; i++) begin
      send(eff_tab[7 - i], p1_tab[i], b1_tab[7 - i], 0, 1'b0);
      if (i == 0) chk("r2_hard_restart", int'(stg_hard), 5);
    end
    chk("r2_done", int'(done), 1);
    chk("r2_pass_cnt", int'(pass_cnt), m_pc);
    step();

`ifdef GAME_STAGE_DRV_ABORT_EN
    // Round 3: abort in DRIVE of player 2
    mode = 0;
    do_start();
    send(20, 1, 0, 0, 1'b0);
    send(30, 1, 0, 0, 1'b0);
    eff_effort = 7'd40;
    eff_valid  = 1'b1;
    step();
    eff_valid  = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ready", int'(eff_ready), 0);
    chk("abort_pass_cnt", int'(pass_cnt), 2);
    chk("abort_bonus_sum", int'(bonus_sum), 4);
    repeat (4) begin
      step();
      chk("abort_no_done", int'(done), 0);
      chk("abort_no_res", int'(res_valid), 0);
    end
`endif

    repeat (3) step();
    chk("res_q_empty", res_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_stage_driver.md
Name: game_stage_driver

Overview:
- Sequential front end for the combinational game-stage evaluator. It is the producer side of that evaluator's interface.
- Per player, it accepts effort plus the previous-stage pass/bonus over a valid/ready handshake.
- It generates the `hard` and `random2` operands from an internal LFSR, presents all operands to the evaluator, and samples the returned pass2/bonus2.
- After NUM_PLAYERS rounds it reports per-player results and round totals.

Parameters:
- NUM_PLAYERS, 8, players per round (1..15).
- CNT_W, 4, width of player index and pass counter; must satisfy 2**CNT_W > NUM_PLAYERS.
- LFSR_SEED, 10'h2A5, LFSR value loaded at reset and at each accepted start.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a round; accepted only in IDLE.
- eff_valid  input  1  player record valid.
- eff_ready  output  1  driver can accept a record.
- eff_effort  input  7  player effort.
- eff_pass1  input  1  previous-stage pass.
- eff_bonus1  input  2  previous-stage bonus.
- stg_effort  output  7  to evaluator.
- stg_hard  output  5  to evaluator.
- stg_random2  output  5  to evaluator.
- stg_pass1  output  1  to evaluator.
- stg_bonus1  output  2  to evaluator.
- stg_pass2  input  1  from evaluator (combinational).
- stg_bonus2  input  2  from evaluator (combinational).
- res_valid  output  1  one-cycle pulse per sampled player.
- res_idx  output  CNT_W  player index, 0-based.
- res_pass  output  1  sampled pass2.
- res_bonus  output  2  sampled bonus2.
- done  output  1  one-cycle pulse at end of round.
- pass_cnt  output  CNT_W  passes this round.
- bonus_sum  output  CNT_W+2  sum of bonus2 this round.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - All outputs 0, state IDLE, LFSR = LFSR_SEED.
  - A seed of 0 is replaced by 10'h001; the LFSR is never all-zero.
- FSM:
  - IDLE:
    - eff_ready=0.
    - start=1 → LOAD; clears idx, pass_cnt and bonus_sum, reloads LFSR.
  - LOAD:
    - eff_ready=1.
    - On eff_valid&eff_ready, register effort/pass1/bonus1 into stg_* outputs.
    - Set stg_hard=lfsr[4:0] and stg_random2=lfsr[9:5] → DRIVE.
  - DRIVE:
    - eff_ready=0; stg_* held stable for one full cycle (settling time for the evaluator) → SAMPLE.
  - SAMPLE:
    - Capture stg_pass2/stg_bonus2 into res_pass/res_bonus and pulse res_valid with res_idx=idx.
    - pass_cnt += pass2; bonus_sum += bonus2.
    - Advance LFSR.
    - If idx==NUM_PLAYERS-1 → DONE; else idx+1 → LOAD.
  - DONE:
    - Pulse done; pass_cnt/bonus_sum hold final values until the next accepted start → IDLE.
- Latency: record accepted at edge N; res_valid high in the cycle after edge N+2. Minimum 3 cycles per player.
- LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1; next = {lfsr[8:0], lfsr[9]^lfsr[6]}. Advances only in SAMPLE.
- Arithmetic: counters are unsigned. bonus_sum max 3*15=45 fits CNT_W+2; no saturation needed.
- Boundary cases:
  - start outside IDLE: ignored.
  - eff_valid outside LOAD: ignored, no side effects.
  - eff_valid held low in LOAD: wait indefinitely, stg_* hold last values.
  - NUM_PLAYERS=1: LOAD→DRIVE→SAMPLE→DONE once.
  - rst_n low mid-round: immediate return to IDLE, all outputs cleared, partial results discarded.
- stg_* outputs are registered only (no combinational path from eff_* to stg_*).

Optional Feature:
- Macro: GAME_STAGE_DRV_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in LOAD/DRIVE/SAMPLE → IDLE next edge.
  - No res_valid and no done for the interrupted player.
  - pass_cnt/bonus_sum keep partial totals; LFSR is not advanced.
  - abort in IDLE/DONE has no effect.
- Undefined: no abort port; a round always runs to DONE.

Decomposition:
- Shared package game_pkg holds:
  - state typedef (IDLE, LOAD, DRIVE, SAMPLE, DONE);
  - LFSR width 10 and tap positions;
  - field widths: EFFORT_W=7, HARD_W=5, RAND_W=5, BONUS_W=2.
- One natural sub-module: game_lfsr10 (seed load, enable, zero-seed guard, value output).

Test Plan:
- Reset, start, one record effort=90/pass1=1/bonus1=0 → stg_hard=5, stg_random2=21; LFSR after SAMPLE = 10'h14B, second player gets hard=11, random2=10.
- NUM_PLAYERS=8, evaluator model returning pass2=1/bonus2=2'b10 always → 8 res_valid pulses, idx 0..7, then done with pass_cnt=8, bonus_sum=16.
- eff_valid held low 5 cycles in LOAD → eff_ready stays 1, no res_valid, stg_* unchanged; then valid → resumes with normal 3-cycle latency.
- start pulsed during DRIVE, eff_valid pulsed during SAMPLE → no effect on idx, counters or LFSR sequence.
- rst_n deasserted asynchronously mid-DRIVE on player 3 → all outputs 0 immediately; a new start restarts at idx 0 with hard=5.
- With GAME_STAGE_DRV_ABORT_EN: abort in DRIVE of player 2 after two passes → IDLE, pass_cnt=2, no done, no third res_valid.
